// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with water level, error pulses, flush, optional output register and FWFT head.
// Read latency 1 (2 with OUT_REG); FWFT shows head 1 edge after write; no backpressure, see full/overflow.
module sync_fifo_wl #(
  parameter int ADDR_WIDTH       = 5,
  parameter int DATA_WIDTH       = 16,
  parameter int OUT_REG          = 0,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 26,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   water_level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = LW'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = LW'(ALMOST_EMPTY_NUM);
  localparam bit USE_OREG = (OUT_REG != 0) && (FWFT == 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic                  head_vld;
  logic                  head_vld_nxt;
  logic [DATA_WIDTH-1:0] head_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_rd;
  logic                  ram_has_word;
  logic                  empty_nxt;

  always_comb begin
    wr_acc       = wr_en & ~full & ~clr;
    rd_acc       = rd_en & ~empty & ~clr;
    // level counts the FWFT head word too, so RAM holds level minus head_vld words
    ram_has_word = level > LW'(head_vld);
    ram_rd       = 1'b0;
    head_vld_nxt = 1'b0;
    if (FWFT != 0) begin
      ram_rd = ~clr & (~head_vld | rd_acc) & ram_has_word;
      if (clr)
        head_vld_nxt = 1'b0;
      else if (ram_rd)
        head_vld_nxt = 1'b1;
      else if (rd_acc)
        head_vld_nxt = 1'b0;
      else
        head_vld_nxt = head_vld;
    end else begin
      ram_rd = rd_acc;
    end
  end

  always_comb begin
    level_nxt = level;
    if (clr)
      level_nxt = '0;
    else
      level_nxt = level + LW'(wr_acc) - LW'(rd_acc);
    empty_nxt = (FWFT != 0) ? ~head_vld_nxt : (level_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      head_vld     <= 1'b0;
      head_q       <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      water_level  <= '0;
    end else begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc)
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (ram_rd)
          rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      level    <= level_nxt;
      head_vld <= head_vld_nxt;
      if (clr)
        head_q <= '0;
      else if (ram_rd)
        head_q <= mem[rd_ptr];
      full         <= (level_nxt == DEPTH_LVL);
      almost_full  <= (level_nxt >= AF_LVL);
      empty        <= empty_nxt;
      almost_empty <= (level_nxt <= AE_LVL);
      overflow     <= wr_en & full & ~clr;
      underflow    <= rd_en & empty & ~clr;
      water_level  <= level_nxt;
    end
  end

  generate
    if (USE_OREG) begin : g_oreg
      logic [DATA_WIDTH-1:0] out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          out_q <= '0;
        else if (clr)
          out_q <= '0;
        else
          out_q <= head_q;
      end
      assign rd_data = out_q;
    end else begin : g_direct
      assign rd_data = head_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Bench for sync_fifo_wl: standard, output-register and FWFT instances checked against a queue model.
module tb_sync_fifo_wl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // group A drives the standard and OUT_REG instances, group B the FWFT instance
  logic clr_a, wr_en_a, rd_en_a;
  logic [15:0] wr_data_a;
  logic clr_b, wr_en_b, rd_en_b;
  logic [15:0] wr_data_b;

  logic s_full, s_af, s_ovf, s_empty, s_ae, s_unf;
  logic [15:0] s_rd;
  logic [5:0]  s_wl;
  logic o_full, o_af, o_ovf, o_empty, o_ae, o_unf;
  logic [15:0] o_rd;
  logic [5:0]  o_wl;
  logic f_full, f_af, f_ovf, f_empty, f_ae, f_unf;
  logic [15:0] f_rd;
  logic [5:0]  f_wl;

  sync_fifo_wl #(.OUT_REG(0), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(s_full), .almost_full(s_af), .overflow(s_ovf), .rd_en(rd_en_a), .rd_data(s_rd),
    .empty(s_empty), .almost_empty(s_ae), .underflow(s_unf), .water_level(s_wl));

  sync_fifo_wl #(.OUT_REG(1), .FWFT(0)) u_oreg (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(o_full), .almost_full(o_af), .overflow(o_ovf), .rd_en(rd_en_a), .rd_data(o_rd),
    .empty(o_empty), .almost_empty(o_ae), .underflow(o_unf), .water_level(o_wl));

  sync_fifo_wl #(.OUT_REG(0), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(f_full), .almost_full(f_af), .overflow(f_ovf), .rd_en(rd_en_b), .rd_data(f_rd),
    .empty(f_empty), .almost_empty(f_ae), .underflow(f_unf), .water_level(f_wl));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model A: word queue plus expected read registers
  logic [15:0] a_q[$];
  int          a_level = 0;
  logic [15:0] a_rd = '0;
  logic [15:0] a_ord = '0;

  task automatic step_a(input logic w, input logic [15:0] d, input logic r, input logic c);
    logic wacc, racc, eovf, eunf;
    logic [15:0] rd_prev;
    @(negedge clk);
    wr_en_a = w; wr_data_a = d; rd_en_a = r; clr_a = c;
    wacc = w && (a_level != 32) && !c;
    racc = r && (a_level != 0) && !c;
    eovf = w && (a_level == 32) && !c;
    eunf = r && (a_level == 0) && !c;
    rd_prev = a_rd;
    if (c) begin
      a_q.delete(); a_level = 0; a_rd = '0; a_ord = '0;
    end else begin
      a_ord = rd_prev;
      if (racc) a_rd = a_q.pop_front();
      if (wacc) a_q.push_back(d);
      a_level = a_level + int'(wacc) - int'(racc);
    end
    @(posedge clk); #1;
    chk("std_rd_data", s_rd, a_rd);
    chk("oreg_rd_data", o_rd, a_ord);
    chk("water_level", s_wl, a_level);
    chk("full", s_full, a_level == 32);
    chk("almost_full", s_af, a_level >= 26);
    chk("empty", s_empty, a_level == 0);
    chk("almost_empty", s_ae, a_level <= 4);
    chk("overflow", s_ovf, eovf);
    chk("underflow", s_unf, eunf);
    chk("oreg_flags", {o_full, o_af, o_empty, o_ae, o_ovf, o_unf, o_wl},
        {s_full, s_af, s_empty, s_ae, s_ovf, s_unf, s_wl});
  endtask

  // model B: a head word is visible once an edge has passed since it was written
  typedef struct { logic [15:0] d; int t; } ent_t;
  ent_t fq[$];
  int   b_edge = 0;

  task automatic step_b(input logic w, input logic [15:0] d, input logic r, input logic c);
    logic vis_pre, vis, wacc, pop, eovf, eunf;
    ent_t e;
    @(negedge clk);
    wr_en_b = w; wr_data_b = d; rd_en_b = r; clr_b = c;
    b_edge++;
    vis_pre = (fq.size() > 0) && (fq[0].t < b_edge - 1);
    pop  = r && vis_pre && !c;
    wacc = w && (fq.size() < 32) && !c;
    eovf = w && (fq.size() == 32) && !c;
    eunf = r && !vis_pre && !c;
    if (c) fq.delete();
    else begin
      if (pop) void'(fq.pop_front());
      if (wacc) begin e.d = d; e.t = b_edge; fq.push_back(e); end
    end
    vis = (fq.size() > 0) && (fq[0].t < b_edge);
    @(posedge clk); #1;
    chk("fwft_empty", f_empty, !vis);
    if (vis) chk("fwft_rd_data", f_rd, fq[0].d);
    if (c) chk("fwft_clr_rd_data", f_rd, 16'h0);
    chk("fwft_water_level", f_wl, fq.size());
    chk("fwft_full", f_full, fq.size() == 32);
    chk("fwft_almost_full", f_af, fq.size() >= 26);
    chk("fwft_almost_empty", f_ae, fq.size() <= 4);
    chk("fwft_overflow", f_ovf, eovf);
    chk("fwft_underflow", f_unf, eunf);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_std"}, {s_empty, s_ae, s_full, s_af, s_ovf, s_unf, s_rd, s_wl}, {6'b110000, 16'h0, 6'h0});
    chk({tag, "_oreg"}, {o_empty, o_ae, o_full, o_af, o_ovf, o_unf, o_rd, o_wl}, {6'b110000, 16'h0, 6'h0});
    chk({tag, "_fwft"}, {f_empty, f_ae, f_full, f_af, f_ovf, f_unf, f_rd, f_wl}, {6'b110000, 16'h0, 6'h0});
  endtask

  task automatic async_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    wr_en_a = 0; rd_en_a = 0; clr_a = 0; wr_en_b = 0; rd_en_b = 0; clr_b = 0;
    a_q.delete(); a_level = 0; a_rd = '0; a_ord = '0; fq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic w; logic [15:0] d; logic r; logic c;
    int lvl; logic emp; logic [15:0] rd; logic unf;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{w:1, d:16'h0011, r:0, c:0, lvl:1, emp:0, rd:16'h0000, unf:0};
    tbl[1]  = '{w:1, d:16'h0022, r:0, c:0, lvl:2, emp:0, rd:16'h0000, unf:0};
    tbl[2]  = '{w:0, d:16'h0000, r:1, c:0, lvl:1, emp:0, rd:16'h0011, unf:0};
    tbl[3]  = '{w:1, d:16'h0033, r:1, c:0, lvl:1, emp:0, rd:16'h0022, unf:0};
    tbl[4]  = '{w:0, d:16'h0000, r:1, c:0, lvl:0, emp:1, rd:16'h0033, unf:0};
    tbl[5]  = '{w:0, d:16'h0000, r:1, c:0, lvl:0, emp:1, rd:16'h0033, unf:1};
    tbl[6]  = '{w:0, d:16'h0000, r:0, c:0, lvl:0, emp:1, rd:16'h0033, unf:0};
    tbl[7]  = '{w:1, d:16'h0044, r:0, c:0, lvl:1, emp:0, rd:16'h0033, unf:0};
    tbl[8]  = '{w:1, d:16'h0055, r:1, c:1, lvl:0, emp:1, rd:16'h0000, unf:0};
    tbl[9]  = '{w:0, d:16'h0000, r:1, c:1, lvl:0, emp:1, rd:16'h0000, unf:0};
    tbl[10] = '{w:1, d:16'h0066, r:1, c:0, lvl:1, emp:0, rd:16'h0000, unf:1};
    tbl[11] = '{w:0, d:16'h0000, r:1, c:0, lvl:0, emp:1, rd:16'h0066, unf:0};

    rst_n = 1'b0;
    clr_a = 0; wr_en_a = 0; rd_en_a = 0; wr_data_a = '0;
    clr_b = 0; wr_en_b = 0; rd_en_b = 0; wr_data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step_a(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_level", i), s_wl, tbl[i].lvl);
      chk($sformatf("tbl%0d_empty", i), s_empty, tbl[i].emp);
      chk($sformatf("tbl%0d_rd_data", i), s_rd, tbl[i].rd);
      chk($sformatf("tbl%0d_underflow", i), s_unf, tbl[i].unf);
    end

    // fill, overflow, drain, underflow
    for (int i = 1; i <= 32; i++) begin
      step_a(1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 25) chk("fill_af_below", s_af, 1'b0);
      if (i == 26) chk("fill_af_at", s_af, 1'b1);
    end
    chk("fill_full", s_full, 1'b1);
    chk("fill_level", s_wl, 6'd32);
    step_a(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("ovf_pulse", s_ovf, 1'b1);
    step_a(1'b0, 16'h0, 1'b0, 1'b0);
    chk("ovf_clear", s_ovf, 1'b0);
    chk("ovf_level", s_wl, 6'd32);
    for (int i = 1; i <= 32; i++) begin
      step_a(1'b0, 16'h0, 1'b1, 1'b0);
      chk("drain_order", s_rd, 16'(i));
      if (i == 28) chk("drain_ae_at", s_ae, 1'b1);
    end
    chk("drain_empty", s_empty, 1'b1);
    step_a(1'b0, 16'h0, 1'b0, 1'b0);
    chk("drain_oreg_last", o_rd, 16'd32);
    step_a(1'b0, 16'h0, 1'b1, 1'b0);
    chk("unf_pulse", s_unf, 1'b1);
    chk("unf_rd_hold", s_rd, 16'd32);
    step_a(1'b0, 16'h0, 1'b0, 1'b0);

    // concurrent traffic at level 10 across pointer wrap, then at full
    for (int i = 0; i < 10; i++) step_a(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step_a(1'b1, 16'($urandom), 1'b1, 1'b0);
    chk("conc_level", s_wl, 6'd10);
    for (int i = 0; i < 22; i++) step_a(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step_a(1'b1, 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 40; i++)
      step_a(1'($urandom), 16'($urandom), 1'($urandom), 1'b0);

    // flush at level 17, then reset mid-burst
    step_a(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step_a(1'b1, 16'($urandom), 1'b0, 1'b0);
    chk("pre_clr_level", s_wl, 6'd17);
    step_a(1'b1, 16'h1234, 1'b1, 1'b1);
    chk("clr_empty", s_empty, 1'b1);
    chk("clr_level", s_wl, 6'd0);
    for (int i = 0; i < 5; i++) step_a(1'b1, 16'($urandom), 1'b0, 1'b0);
    wr_en_a = 1'b1;
    async_reset();
    step_a(1'b1, 16'hBEEF, 1'b0, 1'b0);
    step_a(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post_reset_rd", s_rd, 16'hBEEF);

    // FWFT: single word appears without rd_en
    step_b(1'b1, 16'hA5A5, 1'b0, 1'b0);
    chk("fwft_one_edge_empty", f_empty, 1'b1);
    step_b(1'b0, 16'h0, 1'b0, 1'b0);
    chk("fwft_two_edge_empty", f_empty, 1'b0);
    chk("fwft_two_edge_data", f_rd, 16'hA5A5);
    step_b(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fwft_pop_empty", f_empty, 1'b1);
    step_b(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fwft_unf", f_unf, 1'b1);
    for (int i = 0; i < 16; i++) step_b(1'b1, 16'h100 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("fwft_stream_ready", f_empty, 1'b0);
      chk("fwft_stream_data", f_rd, 16'h100 + 16'(i));
      step_b(1'b0, 16'h0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) step_b(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step_b(1'b1, 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step_b(1'b1, 16'($urandom), 1'b0, 1'b0);
    chk("fwft_full", f_full, 1'b1);
    for (int i = 0; i < 4; i++) step_b(1'b1, 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 60; i++)
      step_b(1'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    step_b(1'b1, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 36; i++) step_b(1'b0, 16'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
